// File: rtl/al_ram_reader_if.sv
// al_ram_reader_if: drain request, RAM read port and symbol output stream of one aligned-RAM reader
interface al_ram_reader_if #(parameter int N = 128, parameter int BitAddr = $clog2(N));
  logic start;
  logic [BitAddr:0] len;
  logic [BitAddr:0] rd_addr;
  logic [2:0] ram_data;
  logic [2:0] out_code;
  logic [7:0] out_char;
  logic out_valid;
  logic out_ready;
  logic busy;
  logic done;
  modport master (input start, len, ram_data, out_ready, output rd_addr, out_code, out_char, out_valid, busy, done);
  modport slave (output start, len, ram_data, out_ready, input rd_addr, out_code, out_char, out_valid, busy, done);
endinterface

// File: rtl/al_ram_reader.sv
// al_ram_reader: walks an aligned-sequence RAM from index 0 and streams each symbol as ASCII over valid/ready
module al_ram_reader #(parameter int N = 128, parameter int BitAddr = $clog2(N)) (
  input logic clk,
  input logic rst,
  al_ram_reader_if.master bus
);
  localparam int W = BitAddr + 1;
  localparam logic [W-1:0] NMAX = W'(N);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, HOLD, FIN} state_t;
  state_t state_q, state_d;
  logic [W-1:0] idx_q, idx_d, cnt_max_q, cnt_max_d;
  logic [2:0] out_code_q, out_code_d;
  logic [7:0] out_char_q, out_char_d, dec;
  always_comb
    dec = bus.ram_data == 3'd0 ? 8'h41 :
          bus.ram_data == 3'd1 ? 8'h43 :
          bus.ram_data == 3'd2 ? 8'h47 :
          bus.ram_data == 3'd3 ? 8'h54 :
          bus.ram_data == 3'd4 ? 8'h2D : 8'h3F;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cnt_max_d = cnt_max_q;
    out_code_d = out_code_q;
    out_char_d = out_char_q;
    case (state_q)
      IDLE: if (bus.start) begin
        cnt_max_d = bus.len > NMAX ? NMAX : bus.len;
        idx_d = '0;
        state_d = bus.len == '0 ? FIN : ADDR;
      end
      ADDR: state_d = DATA;
      DATA: begin
        out_code_d = bus.ram_data;
        out_char_d = dec;
        state_d = HOLD;
      end
      HOLD: if (bus.out_ready) begin
        state_d = idx_q == cnt_max_q - 1'b1 ? FIN : ADDR;
        idx_d = idx_q == cnt_max_q - 1'b1 ? idx_q : idx_q + 1'b1;
      end
      FIN: begin
        idx_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      cnt_max_q <= '0;
      out_code_q <= '0;
      out_char_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cnt_max_q <= cnt_max_d;
      out_code_q <= out_code_d;
      out_char_q <= out_char_d;
    end
  assign bus.rd_addr = idx_q;
  assign bus.out_code = out_code_q;
  assign bus.out_char = out_char_q;
  assign bus.out_valid = state_q == HOLD;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == FIN;
endmodule

// File: tb/tb_al_ram_reader.sv
// tb_al_ram_reader: directed and randomized drains checked against a symbol-list model of the RAM
module tb_al_ram_reader;
  localparam int N = 128;
  localparam int W = $clog2(N) + 1;
  logic clk = 0;
  logic rst = 0;
  int checks = 0;
  int passes = 0;
  int fails = 0;
  logic [2:0] ram [N];
  al_ram_reader_if #(.N(N)) bus();
  al_ram_reader #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) bus.ram_data <= ram[bus.rd_addr[W-2:0]];

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    assert (act === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle_watch(int cycles);
    bus.start = 0;
    repeat (cycles) begin
      chk("idle_done", bus.done, 0);
      chk("idle_valid", bus.out_valid, 0);
      chk("idle_busy", bus.busy, 0);
      chk("idle_addr", bus.rd_addr, 0);
      @(negedge clk);
    end
  endtask

  // Expected stream: symbols ram[0..min(l,N)-1], one every 3 cycles plus stall cycles.
  task automatic drain(int l, int stall_idx, int stall_n, int extra_cyc);
    string lut = "ACGT-???";
    int n = l > N ? N : l;
    int got = 0;
    int cyc = 1;
    int left = stall_n;
    bit fin = 0;
    bit seen = 0;
    @(negedge clk);
    bus.start = 1;
    bus.len = W'(l);
    bus.out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.start = 0;
    chk("busy_t1", bus.busy, 1);
    while (!fin && cyc < 3 * N + 64) begin
      bus.start = cyc == extra_cyc;
      if (bus.out_valid) begin
        chk("valid_done_excl", bus.done, 0);
        if (!seen) chk("first_latency", cyc, 3);
        seen = 1;
        chk("sym_in_range", got < n, 1);
        if (got < n) begin
          chk("char", bus.out_char, 32'(lut[ram[got]]));
          chk("code", bus.out_code, ram[got]);
          chk("rd_addr", bus.rd_addr, got);
        end
        bus.out_ready = !(got == stall_idx && left > 0);
        if (bus.out_ready) got++;
        else left--;
      end else bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.done) begin
        fin = 1;
        chk("done_cycle", cyc, n == 0 ? 1 : 3 * n + (stall_n - left) + 1);
        chk("sym_count", got, n);
        chk("busy_fin", bus.busy, 1);
      end
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", fin, 1);
    idle_watch(8);
  endtask

  initial begin
    bit found = 0;
    bus.start = 0;
    bus.len = '0;
    bus.out_ready = 0;
    for (int i = 0; i < N; i++) ram[i] = 3'(i);
    #1 rst = 1;
    #2;
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_code", bus.out_code, 0);
    chk("rst_char", bus.out_char, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    drain(5, -1, 0, -1);
    drain(5, 2, 4, -1);
    for (int i = 0; i < N; i++) ram[i] = 3'b111;
    drain(N + 1, -1, 0, -1);
    drain(0, -1, 0, -1);
    for (int i = 0; i < N; i++) ram[i] = 3'($urandom_range(0, 7));
    drain(3, -1, 0, 4);
    for (int i = 0; i < 5; i++) ram[i] = 3'(i);
    @(negedge clk);
    bus.start = 1;
    bus.len = W'(5);
    @(negedge clk);
    bus.start = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (bus.out_valid && bus.rd_addr == 1) begin
        bus.out_ready = 0;
        found = 1;
      end else begin
        bus.out_ready = 1;
        @(negedge clk);
      end
    end
    chk("reach_hold_sym1", found, 1);
    #1 rst = 1;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_rd_addr", bus.rd_addr, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    #1 rst = 0;
    @(negedge clk);
    idle_watch(10);
    drain(5, -1, 0, -1);
    for (int r = 0; r < 4; r++) begin
      int l = $urandom_range(0, 20);
      for (int i = 0; i < N; i++) ram[i] = 3'($urandom_range(0, 7));
      drain(l, $urandom_range(0, l), $urandom_range(0, 5), $urandom_range(2, 9));
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/al_ram_reader.md
# al_ram_reader

Sequential read-out engine for an aligned-sequence RAM after traceback has filled it. On `start` it walks RAM indices 0 to `len`-1, fetches each 3-bit alignment symbol through the RAM's registered-address read port, and decodes it to ASCII. Each symbol is presented on a valid/ready output stream, so alignment results can be drained to a UART/host bridge. One instance serves each aligned RAM (A or B). The top level muxes `rd_addr` onto the RAM index port whenever `en_traceB` is low.

## Interface
- `N`, 128, RAM depth in symbols
- `BitAddr`, $clog2(N), index width minus one. The index ports are BitAddr+1 bits, matching the RAM index port.

- `clk`  in  1  single clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle request to begin draining. Sampled only in IDLE.
- `len`  in  BitAddr+1  number of symbols to drain, sampled with `start`
- `rd_addr`  out  BitAddr+1  RAM read index
- `ram_data`  in  3  RAM read data. Valid the cycle after `rd_addr` has been held across a rising edge.
- `out_code`  out  3  raw symbol code
- `out_char`  out  8  ASCII-decoded symbol
- `out_valid`  out  1  output symbol valid
- `out_ready`  in  1  downstream accepts the symbol
- `busy`  out  1  high whenever state is not IDLE
- `done`  out  1  one-cycle pulse when draining completes

## Operation
- Decode:
  - 3'b000 → 'A' (0x41)
  - 3'b001 → 'C' (0x43)
  - 3'b010 → 'G' (0x47)
  - 3'b011 → 'T' (0x54)
  - 3'b100 → '-' (0x2D), gap
  - 3'b101–3'b111 → '?' (0x3F)
- `len` is clamped to N when larger: effective length `cnt_max = min(len, N)`. The index counter `idx` is BitAddr+1 bits and never exceeds N-1.
- FSM states: IDLE, ADDR, DATA, HOLD, FIN.
  - IDLE: `start`=1 with `cnt_max`=0 → FIN. `start`=1 otherwise → ADDR with `idx`=0.
  - ADDR: drive `rd_addr`=`idx` → DATA.
  - DATA: `rd_addr` still `idx`. Register `ram_data` into `out_code` and its decode into `out_char` → HOLD.
  - HOLD: `out_valid`=1. If `out_ready`=1:
    - `idx`=`cnt_max`-1 → FIN
    - otherwise `idx`++ → ADDR
  - FIN: `done`=1 for this single cycle → IDLE.
- `rd_addr` equals `idx` in every state. It is 0 in IDLE and after reset.
- `start` outside IDLE is ignored. It is neither queued nor allowed to restart the walk.
- `out_code`/`out_char` are stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Reset values (immediate, asynchronous):
  - state=IDLE, `idx`=0, `rd_addr`=0
  - `out_code`=0, `out_char`=0x00
  - `out_valid`=0, `busy`=0, `done`=0
- Reset asserted mid-drain aborts the drain. No `done` pulse is produced, and the next drain requires a new `start`.
- Latency:
  - `start` at edge t → ADDR in cycle t+1.
  - First `out_valid` in cycle t+3.
  - With `out_ready` held high, one symbol every 3 cycles.
  - `done` is asserted in the cycle after the final handshake.
- Handshake:
  - A transfer occurs on a rising edge where `out_valid`=1 and `out_ready`=1.
  - `out_valid` drops in the cycle after the transfer.
  - `out_ready` is allowed to be high before `out_valid` rises. It has no effect outside HOLD.
- `len`=0: `done` pulses in cycle t+1, `out_valid` never asserts, `rd_addr` stays 0.
- `busy` is high from cycle t+1 through the FIN cycle inclusive.
- `done` and `out_valid` are never high in the same cycle.

## Test plan
- Basic drain:
  - Stimulus: RAM preloaded [0,1,2,3,4] (indices 0–4), `len`=5, `out_ready`=1.
  - Required response: chars "ACGT-" in order, `rd_addr` sequence 0..4, first valid 3 cycles after `start`, `done` 1 cycle after the 5th transfer.
- Backpressure:
  - Stimulus: same preload, `out_ready` low for 4 cycles on symbol index 2.
  - Required response: `out_char`=0x47 held stable with `out_valid`=1 throughout the stall, no symbols lost or duplicated.
- Invalid codes and clamp:
  - Stimulus: RAM[0..N-1]=3'b111, `len`=N+1 (within BitAddr+1 bits).
  - Required response: exactly N symbols, each 0x3F, last `rd_addr`=N-1, then `done`.
- Zero length and ignored start:
  - Stimulus: `len`=0.
  - Required response: `done` at t+1, no `out_valid`.
  - Stimulus: second `start` pulsed during a `len`=3 drain.
  - Required response: exactly 3 symbols, one `done`.
- Async reset mid-drain:
  - Stimulus: `rst` pulsed between clock edges while in HOLD on symbol 1.
  - Required response: `out_valid`=0 and `rd_addr`=0 immediately, no `done` pulse.
  - Stimulus: a fresh `start` afterward.
  - Required response: drain restarts from index 0.
